// File: rtl/inv_decoder.sv
`default_nettype none
// ============================================================================
// Module   : inv_decoder
// Purpose  : First-word-fall-through FIFO that stores each word in true form,
//            undoing an optional bus inversion on the way in.
// Revision : 1.0
// ============================================================================
module inv_decoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rest,
  input  logic                       ce,
  input  logic                       inv,
  input  logic [15:0]                data_in,
  input  logic                       rd_en,
  output logic                       ready,
  output logic                       valid_out,
  output logic [15:0]                data_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 inv_cnt,
  output logic                       ovf,
  output logic                       udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    inv_cnt_q, inv_cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_word;

  // Flow control depends only on the registered occupancy, never on inputs.
  assign ready     = (count_q != CW'(DEPTH));
  assign valid_out = (count_q != '0);
  assign data_out  = valid_out ? mem_q[rd_ptr_q] : 16'h0000;
  assign count     = count_q;
  assign inv_cnt   = inv_cnt_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

  assign w_push = ce & ready;
  assign w_pop  = rd_en & valid_out;
  assign w_word = inv ? ~data_in : data_in;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    inv_cnt_d = inv_cnt_q;
    ovf_d    = ovf_q | (ce & ~ready);
    udf_d    = udf_q | (rd_en & ~valid_out);

    if (w_push) begin
      mem_d[wr_ptr_q] = w_word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      if (inv && (inv_cnt_q != 8'hFF)) begin
        inv_cnt_d = inv_cnt_q + 8'd1;
      end
    end

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rest) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      inv_cnt_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      inv_cnt_q <= inv_cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage needs no reset: data_out is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_decoder
// Purpose  : Directed self-checking bench for inv_decoder with DEPTH = 4.
// Revision : 1.0
// ============================================================================
module tb_inv_decoder;

  logic        clk;
  logic        rest;
  logic        ce;
  logic        inv;
  logic [15:0] data_in;
  logic        rd_en;
  logic        ready;
  logic        valid_out;
  logic [15:0] data_out;
  logic [2:0]  count;
  logic [7:0]  inv_cnt;
  logic        ovf;
  logic        udf;

  int total_checks;
  int failed_checks;

  inv_decoder #(.DEPTH(4)) dut (
    .clk       (clk),
    .rest      (rest),
    .ce        (ce),
    .inv       (inv),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .ready     (ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .count     (count),
    .inv_cnt   (inv_cnt),
    .ovf       (ovf),
    .udf       (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    assert (obs === exp)
    else begin
      failed_checks++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"},   32'(count),     32'd0);
    chk({tag, "_valid"},   32'(valid_out), 32'd0);
    chk({tag, "_ready"},   32'(ready),     32'd1);
    chk({tag, "_data"},    32'(data_out),  32'h0000);
    chk({tag, "_inv_cnt"}, 32'(inv_cnt),   32'd0);
    chk({tag, "_ovf"},     32'(ovf),       32'd0);
    chk({tag, "_udf"},     32'(udf),       32'd0);
  endtask

  initial begin
    total_checks  = 0;
    failed_checks = 0;
    rest    = 1'b0;
    ce      = 1'b0;
    inv     = 1'b0;
    data_in = 16'h0000;
    rd_en   = 1'b0;
    tick();
    tick();
    chk_reset_state("reset");

    // First edge after reset release accepts a push, one cycle to the output
    rest = 1'b1; ce = 1'b1; inv = 1'b0; data_in = 16'hF0F0;
    tick();
    ce = 1'b0;
    chk("p1_data",    32'(data_out),  32'hF0F0);
    chk("p1_valid",   32'(valid_out), 32'd1);
    chk("p1_count",   32'(count),     32'd1);
    chk("p1_inv_cnt", 32'(inv_cnt),   32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("p1_pop_valid", 32'(valid_out), 32'd0);

    // Inverted word is stored decoded
    ce = 1'b1; inv = 1'b1; data_in = 16'hF0F0;
    tick();
    ce = 1'b0; inv = 1'b0;
    chk("inv_data",    32'(data_out), 32'h0F0F);
    chk("inv_inv_cnt", 32'(inv_cnt),  32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("inv_pop_valid", 32'(valid_out), 32'd0);
    chk("inv_pop_data",  32'(data_out),  32'h0000);

    // Fill past full
    for (int i = 1; i <= 5; i++) begin
      ce = 1'b1; data_in = 16'(i);
      tick();
    end
    ce = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(ready), 32'd0);
    chk("full_ovf",   32'(ovf),   32'd1);
    chk("full_head",  32'(data_out), 32'h0001);

    // ce=0 must not disturb contents
    ce = 1'b0; inv = 1'b1; data_in = 16'hFFFF;
    tick();
    inv = 1'b0;
    chk("idle_count", 32'(count), 32'd4);
    chk("idle_head",  32'(data_out), 32'h0001);

    // Full with push+pop: pop happens, push is dropped
    ce = 1'b1; rd_en = 1'b1; data_in = 16'h00AA;
    tick();
    ce = 1'b0;
    chk("fullrw_count", 32'(count), 32'd3);
    chk("fullrw_head",  32'(data_out), 32'h0002);
    tick();
    chk("drain_head3", 32'(data_out), 32'h0003);
    tick();
    chk("drain_head4", 32'(data_out), 32'h0004);
    tick();
    rd_en = 1'b0;
    chk("drain_valid", 32'(valid_out), 32'd0);
    chk("drain_count", 32'(count),     32'd0);
    chk("drain_ready", 32'(ready),     32'd1);

    // Steady push+pop at count=2 across pointer wrap
    ce = 1'b1; data_in = 16'h0101;
    tick();
    data_in = 16'h0102;
    tick();
    chk("rw_count0", 32'(count), 32'd2);
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rw_head", 32'(data_out), 32'(16'h0101 + 16'(k)));
      data_in = 16'h0103 + 16'(k);
      tick();
      chk("rw_count", 32'(count), 32'd2);
    end
    ce = 1'b0;
    chk("rw_tail7", 32'(data_out), 32'h0107);
    tick();
    chk("rw_tail8", 32'(data_out), 32'h0108);
    tick();
    rd_en = 1'b0;
    chk("rw_empty", 32'(valid_out), 32'd0);
    chk("rw_udf_clear", 32'(udf), 32'd0);

    // Underflow, then push on an empty-read edge
    rd_en = 1'b1;
    tick();
    chk("udf_set",   32'(udf),   32'd1);
    chk("udf_count", 32'(count), 32'd0);
    ce = 1'b1; data_in = 16'h1234;
    tick();
    ce = 1'b0; rd_en = 1'b0;
    chk("udf_push_count", 32'(count),    32'd1);
    chk("udf_push_data",  32'(data_out), 32'h1234);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("udf_push_pop", 32'(count), 32'd0);

    // 300 inverted pushes, each popped; inv_cnt starts at 1 and saturates
    ce = 1'b1; inv = 1'b1; rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_in = 16'(i);
      tick();
      if (i == 10) chk("sat_data", 32'(data_out), 32'hFFF5);
      if (i == 252) chk("sat_pre", 32'(inv_cnt), 32'hFE);
    end
    ce = 1'b0; inv = 1'b0;
    tick();
    rd_en = 1'b0;
    chk("sat_inv_cnt", 32'(inv_cnt), 32'hFF);
    chk("sat_count",   32'(count),   32'd0);
    chk("sat_ovf",     32'(ovf),     32'd1);
    chk("sat_udf",     32'(udf),     32'd1);

    // Reset with stored words wins over push/pop
    for (int i = 0; i < 3; i++) begin
      ce = 1'b1; data_in = 16'hA000 + 16'(i);
      tick();
    end
    ce = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    rest = 1'b0; ce = 1'b1; rd_en = 1'b1; inv = 1'b1; data_in = 16'h5555;
    tick();
    ce = 1'b0; rd_en = 1'b0; inv = 1'b0;
    chk_reset_state("rst2");
    rest = 1'b1; ce = 1'b1; data_in = 16'hBEEF;
    tick();
    ce = 1'b0;
    chk("post_rst_count", 32'(count),    32'd1);
    chk("post_rst_data",  32'(data_out), 32'hBEEF);

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

endmodule
`default_nettype wire
